// File: rtl/softmax_max_sub_feed.sv
// Softmax PE feeder: buffers one vector, tracks its signed max, then replays (x[i], -max) pairs.
// Optional SOFTMAX_SAT_SUB_EN clamps pairs whose x - max would underflow the PE sum.
module softmax_max_sub_feed #(
  parameter int DATA_WIDTH = 16,
  parameter int VEC_LEN    = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_in1,
  output logic [DATA_WIDTH-1:0] out_in2,
  output logic                  out_set_reg,
  output logic                  out_last,
  output logic                  busy
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         VEC_LEN_C = CW'(VEC_LEN);
  localparam logic [CW-1:0]         CNT_ONE_C = CW'(1);
  localparam logic [CW-1:0]         CNT_TWO_C = CW'(2);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] MIN_C     = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ZERO_C    = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE_C     = DATA_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]   max_q, max_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_in1_q, out_in1_d;
  logic [DATA_WIDTH-1:0]   out_in2_q, out_in2_d;
  logic                    out_last_q, out_last_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   mem_q [VEC_LEN];

  logic                    accept_s;
  logic                    wr_en_s;
  logic [CW-1:0]           count_inc_s;
  logic [ADDR_WIDTH-1:0]   rd_ptr_inc_s;
  logic [DATA_WIDTH-1:0]   max_upd_s;
  logic [DATA_WIDTH-1:0]   first_x_s;
  logic [2*DATA_WIDTH-1:0] pair_s;

  // Builds the (in1, in2) pair for element x against vector max mx.
  function automatic logic [2*DATA_WIDTH-1:0] pair_fn(
    input logic [DATA_WIDTH-1:0] x,
    input logic [DATA_WIDTH-1:0] mx
  );
    logic [DATA_WIDTH-1:0] neg;
`ifdef SOFTMAX_SAT_SUB_EN
    logic signed [DATA_WIDTH:0] diff;
    logic signed [DATA_WIDTH:0] lim;
`endif
    neg = (~mx) + ONE_C;
`ifdef SOFTMAX_SAT_SUB_EN
    diff = $signed({x[DATA_WIDTH-1], x}) - $signed({mx[DATA_WIDTH-1], mx});
    lim  = $signed({1'b1, MIN_C});
    if (mx == MIN_C) begin
      pair_fn = {x, ZERO_C};
    end else if (diff < lim) begin
      pair_fn = {MIN_C, ZERO_C};
    end else begin
      pair_fn = {x, neg};
    end
`else
    pair_fn = {x, neg};
`endif
  endfunction

  assign in_ready     = (state_q == S_LOAD) && (count_q < VEC_LEN_C);
  assign accept_s     = in_valid && in_ready;
  assign out_set_reg  = out_valid_q && out_ready;
  assign count_inc_s  = count_q + CNT_ONE_C;
  assign rd_ptr_inc_s = rd_ptr_q + PTR_ONE_C;
  assign max_upd_s    = ($signed(in_data) > $signed(max_q)) ? in_data : max_q;
  // The first element may be arriving this very cycle, before it lands in the buffer.
  assign first_x_s    = (count_q == {CW{1'b0}}) ? in_data : mem_q[0];

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    max_d       = max_q;
    out_valid_d = out_valid_q;
    out_in1_d   = out_in1_q;
    out_in2_d   = out_in2_q;
    out_last_d  = out_last_q;
    wr_en_s     = 1'b0;
    pair_s      = {2*DATA_WIDTH{1'b0}};
    case (state_q)
      S_IDLE: begin
        state_d  = S_LOAD;
        count_d  = {CW{1'b0}};
        rd_ptr_d = {ADDR_WIDTH{1'b0}};
        max_d    = MIN_C;
      end
      S_LOAD: begin
        if (accept_s) begin
          wr_en_s = 1'b1;
          count_d = count_inc_s;
          max_d   = max_upd_s;
          if (in_last || (count_inc_s == VEC_LEN_C)) begin
            pair_s      = pair_fn(first_x_s, max_upd_s);
            state_d     = S_DRAIN;
            rd_ptr_d    = {ADDR_WIDTH{1'b0}};
            out_valid_d = 1'b1;
            out_in1_d   = pair_s[2*DATA_WIDTH-1:DATA_WIDTH];
            out_in2_d   = pair_s[DATA_WIDTH-1:0];
            out_last_d  = (count_q == {CW{1'b0}});
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = S_IDLE;
            count_d     = {CW{1'b0}};
            rd_ptr_d    = {ADDR_WIDTH{1'b0}};
            max_d       = MIN_C;
            out_valid_d = 1'b0;
            out_in1_d   = ZERO_C;
            out_in2_d   = ZERO_C;
            out_last_d  = 1'b0;
          end else begin
            pair_s     = pair_fn(mem_q[rd_ptr_inc_s], max_q);
            rd_ptr_d   = rd_ptr_inc_s;
            out_in1_d  = pair_s[2*DATA_WIDTH-1:DATA_WIDTH];
            out_in2_d  = pair_s[DATA_WIDTH-1:0];
            out_last_d = (({1'b0, rd_ptr_q} + CNT_TWO_C) == count_q);
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= {CW{1'b0}};
      rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
      max_q       <= MIN_C;
      out_valid_q <= 1'b0;
      out_in1_q   <= ZERO_C;
      out_in2_q   <= ZERO_C;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      max_q       <= max_d;
      out_valid_q <= out_valid_d;
      out_in1_q   <= out_in1_d;
      out_in2_q   <= out_in2_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  // Element buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[count_q[ADDR_WIDTH-1:0]] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_in1   = out_in1_q;
  assign out_in2   = out_in2_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_softmax_max_sub_feed.sv
// Scoreboard bench for softmax_max_sub_feed; expected pairs are hand-computed constants.
module tb_softmax_max_sub_feed;

  typedef logic [15:0] vec_t [8];
  typedef struct packed {
    logic [15:0] in1;
    logic [15:0] in2;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_in1;
  logic [15:0] out_in2;
  logic        out_set_reg;
  logic        out_last;
  logic        busy;

  int   n_cmp;
  int   n_fail;
  exp_t sb_q[$];

  softmax_max_sub_feed #(.DATA_WIDTH(16), .VEC_LEN(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_ready(out_ready), .out_valid(out_valid), .out_in1(out_in1), .out_in2(out_in2),
    .out_set_reg(out_set_reg), .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic l);
    exp_t e;
    e.in1 = a;
    e.in2 = b;
    e.last = l;
    sb_q.push_back(e);
  endtask

  // Monitor: samples just after the falling edge, which shows what the next rising edge will see.
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid) begin
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pair", {out_in1, out_in2}, 64'hdead);
        end else begin
          check("pair", {out_in1, out_in2, out_last}, {sb_q[0].in1, sb_q[0].in2, sb_q[0].last});
          check("set_reg", 64'(out_set_reg), 64'd1);
          void'(sb_q.pop_front());
        end
      end else if (sb_q.size() != 0) begin
        check("held_pair", {out_in1, out_in2, out_last}, {sb_q[0].in1, sb_q[0].in2, sb_q[0].last});
      end
    end
  end

  task automatic send_vec(input vec_t v, input int n, input bit with_last);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[i];
      in_last  = with_last && (i == n - 1);
      t = 0;
      #1;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drained();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drained", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 16'd0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_outs", {out_valid, out_last, busy, in_ready, out_in1, out_in2}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic vector with backpressure on the second pair.
    push(16'd3, 16'hfff9, 1'b0);
    push(16'hfffb, 16'hfff9, 1'b0);
    push(16'd7, 16'hfff9, 1'b0);
    push(16'd1, 16'hfff9, 1'b1);
    send_vec('{16'd3, 16'hfffb, 16'd7, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0}, 4, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    wait_drained();

    // Full buffer without in_last: truncates at 8.
    push(16'd10, 16'hffd8, 1'b0);
    push(16'd20, 16'hffd8, 1'b0);
    push(16'hfffd, 16'hffd8, 1'b0);
    push(16'd40, 16'hffd8, 1'b0);
    push(16'd5, 16'hffd8, 1'b0);
    push(16'd0, 16'hffd8, 1'b0);
    push(16'hff9c, 16'hffd8, 1'b0);
    push(16'd39, 16'hffd8, 1'b1);
    send_vec('{16'd10, 16'd20, 16'hfffd, 16'd40, 16'd5, 16'd0, 16'hff9c, 16'd39}, 8, 1'b0);
    #1;
    check("full_in_ready", 64'(in_ready), 64'd0);
    wait_drained();

    // Single most-negative element.
`ifdef SOFTMAX_SAT_SUB_EN
    push(16'h8000, 16'h0000, 1'b1);
`else
    push(16'h8000, 16'h8000, 1'b1);
`endif
    send_vec('{16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 1, 1'b1);
    wait_drained();

    // Extreme spread: x - max underflows the PE range.
`ifdef SOFTMAX_SAT_SUB_EN
    push(16'h8000, 16'h0000, 1'b0);
`else
    push(16'h8000, 16'h8001, 1'b0);
`endif
    push(16'h7fff, 16'h8001, 1'b1);
    send_vec('{16'h8000, 16'h7fff, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 2, 1'b1);
    wait_drained();

    // Max not carried over: all-negative vector after a positive one.
    push(16'hfff0, 16'h0002, 1'b0);
    push(16'hfffe, 16'h0002, 1'b1);
    send_vec('{16'hfff0, 16'hfffe, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 2, 1'b1);
    wait_drained();

    // Reset while a pair is stalled in DRAIN.
    out_ready = 1'b0;
    send_vec('{16'd100, 16'd200, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 2, 1'b1);
    #1;
    check("drain_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {out_valid, out_last, busy, in_ready, out_in1, out_in2}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_idle", 64'(in_ready), 64'd0);
    @(negedge clk);
    #1;
    check("post_rst_load", {in_ready, busy, out_valid}, {1'b1, 1'b1, 1'b0});

    // Normal traffic after the aborted vector.
    push(16'd4, 16'hfffc, 1'b0);
    push(16'hfffe, 16'hfffc, 1'b1);
    send_vec('{16'd4, 16'hfffe, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 2, 1'b1);
    wait_drained();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
